serial_add_ctrl: RTL and testbench

Bit-serial adder controller. It sequences a single one-bit full-adder cell (fa) over WIDTH clock cycles to add two WIDTH-bit operands plus carry-in, LSB first. A start/busy/done handshake lets an upstream requester issue additions. The block is the first sequenced user of the combinational full-adder cell and trades area for latency.

---
 rtl/serial_add_pkg.sv | 18 +
 rtl/serial_add_ctrl_fa.sv | 13 +
 rtl/serial_add_ctrl.sv | 102 ++++++++++
 tb/tb_serial_add_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and
// a constant clog2 used to size the bit counter.
package serial_add_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// One-bit combinational full-adder cell.
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: sequences one fa cell over WIDTH cycles, LSB first,
// behind a start/busy/done handshake.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW   = (clog2(WIDTH + 1) < 1) ? 1 : clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_sum, fa_cout;

  fa u_fa (
    .a    (sha_q[0]),
    .b    (shb_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RUN: begin
        sha_d          = sha_q >> 1;
        shb_d          = shb_q >> 1;
        sum_d          = sum_q >> 1;
        sum_d[WIDTH-1] = fa_sum;
        carry_d        = fa_cout;
        cnt_d          = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          cout_d  = fa_cout;
        end
      end
      // IDLE, DONE and the unused encoding all accept a new request.
      default: begin
        if (start) begin
          state_d = S_RUN;
          sha_d   = a;
          shb_d   = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sha_q   <= '0;
      shb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start1 = 1'b0, cin1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  int checks = 0;
  int errors = 0;

  logic [8:0] sb8[$];
  logic [1:0] sb1[$];

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one start pulse on the WIDTH=8 instance and record the expected result.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    sb8.push_back({1'b0, a} + {1'b0, b} + {8'd0, c});
    tick();
    start8 = 1'b0;
  endtask

  // Bounded wait for done8; lat counts edges after the accept edge.
  task automatic wait8(output int lat, output int nbusy);
    lat = 0; nbusy = 0;
    while (!done8 && lat < 40) begin
      if (busy8) nbusy++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy8); end
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done8); end
    checks++; if ({cout8, sum8} !== 9'h000) begin errors++; $display("FAIL reset_result got %h exp 000", {cout8, sum8}); end
    checks++; if ({busy1, done1, cout1, sum1} !== 4'b0) begin errors++; $display("FAIL reset_w1 got %b exp 0000", {busy1, done1, cout1, sum1}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic run_one8(input string nm, input logic [7:0] a, input logic [7:0] b, input logic c);
    int lat, nb;
    logic [8:0] exp;
    issue8(a, b, c);
    wait8(lat, nb);
    checks++; if (lat != 8) begin errors++; $display("FAIL %s_latency got %0d exp 8", nm, lat); end
    checks++; if (nb != 8) begin errors++; $display("FAIL %s_busy_cycles got %0d exp 8", nm, nb); end
    exp = (sb8.size() > 0) ? sb8.pop_front() : 9'h1xx;
    checks++; if ({cout8, sum8} !== exp) begin errors++; $display("FAIL %s_result got %h exp %h", nm, {cout8, sum8}, exp); end
    tick();
    checks++; if (done8 !== 1'b0 || busy8 !== 1'b0) begin errors++; $display("FAIL %s_single_pulse done %b busy %b exp 0 0", nm, done8, busy8); end
    checks++; if ({cout8, sum8} !== exp) begin errors++; $display("FAIL %s_hold got %h exp %h", nm, {cout8, sum8}, exp); end
  endtask

  task automatic test_basic();
    run_one8("basic", 8'h5A, 8'hA5, 1'b0);
  endtask

  task automatic test_carry();
    run_one8("carry_ff01", 8'hFF, 8'h01, 1'b0);
    run_one8("carry_ffff1", 8'hFF, 8'hFF, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++)
      run_one8("rand", 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  task automatic test_back_to_back();
    int lat, nb;
    logic [8:0] exp;
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    sb8.push_back(9'h030);
    tick();
    // Second operands wait at the inputs; start stays high through RUN.
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1;
    sb8.push_back(9'h101);
    wait8(lat, nb);
    checks++; if (lat != 8) begin errors++; $display("FAIL b2b_first_latency got %0d exp 8", lat); end
    exp = (sb8.size() > 0) ? sb8.pop_front() : 9'h1xx;
    checks++; if ({cout8, sum8} !== exp) begin errors++; $display("FAIL b2b_first_result got %h exp %h", {cout8, sum8}, exp); end
    tick();
    start8 = 1'b0;
    lat++;
    checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL b2b_reaccept busy got %b exp 1", busy8); end
    while (!done8 && lat < 60) begin tick(); lat++; end
    checks++; if (lat != 17) begin errors++; $display("FAIL b2b_second_latency got %0d exp 17", lat); end
    exp = (sb8.size() > 0) ? sb8.pop_front() : 9'h1xx;
    checks++; if ({cout8, sum8} !== exp) begin errors++; $display("FAIL b2b_second_result got %h exp %h", {cout8, sum8}, exp); end
    tick();
  endtask

  task automatic test_ignore_start();
    int lat, extra;
    logic [8:0] exp;
    issue8(8'h33, 8'h44, 1'b0);
    tick(); tick(); tick();
    start8 = 1'b1; a8 = 8'h00; b8 = 8'h00;
    tick();
    start8 = 1'b0; a8 = 8'hC3; b8 = 8'h9E; cin8 = 1'b1;
    lat = 4;
    while (!done8 && lat < 40) begin tick(); lat++; end
    checks++; if (lat != 8) begin errors++; $display("FAIL ignore_latency got %0d exp 8", lat); end
    exp = (sb8.size() > 0) ? sb8.pop_front() : 9'h1xx;
    checks++; if ({cout8, sum8} !== exp) begin errors++; $display("FAIL ignore_result got %h exp %h", {cout8, sum8}, exp); end
    extra = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (done8) extra++; end
    checks++; if (extra != 0) begin errors++; $display("FAIL ignore_extra_done got %0d exp 0", extra); end
  endtask

  task automatic test_reset_mid();
    int extra;
    issue8(8'h0F, 8'h01, 1'b0);
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb8.delete();
    checks++; if ({busy8, done8, cout8, sum8} !== 11'h000) begin errors++; $display("FAIL rstmid_state got %h exp 000", {busy8, done8, cout8, sum8}); end
    extra = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (done8 || busy8) extra++; end
    checks++; if (extra != 0) begin errors++; $display("FAIL rstmid_activity got %0d exp 0", extra); end
    run_one8("rstmid_restart", 8'h0F, 8'h01, 1'b0);
  endtask

  task automatic test_width1();
    int lat;
    logic [1:0] exp;
    for (int i = 0; i < 8; i++) begin
      a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i); start1 = 1'b1;
      sb1.push_back(2'(i >> 2 & 1) + 2'(i >> 1 & 1) + 2'(i & 1));
      tick();
      start1 = 1'b0;
      lat = 0;
      while (!done1 && lat < 10) begin tick(); lat++; end
      checks++; if (lat != 1) begin errors++; $display("FAIL w1_latency_%0d got %0d exp 1", i, lat); end
      exp = (sb1.size() > 0) ? sb1.pop_front() : 2'bxx;
      checks++; if ({cout1, sum1} !== exp) begin errors++; $display("FAIL w1_result_%0d got %b exp %b", i, {cout1, sum1}, exp); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_random();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_width1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
